// File: rtl/systolic_row_feeder.sv
// Streams a run of packed row words from the input buffer into the west edge of a
// systolic array, delaying lane k by k cycles so operands meet on the PE diagonal.
module systolic_row_feeder #(
  parameter int ELEM_WIDTH = 8,
  parameter int LANES      = 3,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [LEN_WIDTH-1:0]        i_len,
  input  logic                        i_clr,
  output logic                        o_buf_rd,
  input  logic [LANES*ELEM_WIDTH-1:0] i_buf_data,
  output logic [LANES*ELEM_WIDTH-1:0] o_lane_data,
  output logic [LANES-1:0]            o_lane_valid,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int DW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [DW-1:0]        drn_q, drn_d;
  logic                 buf_rd_q, buf_rd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_vld_q, rd_vld_d;

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
    end
  end

  // Next-state logic; the drain counter covers buffer latency, capture and skew
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    if (i_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      drn_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              state_d = READ;
              cnt_d   = i_len;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        READ: begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;
            drn_d   = DW'(LANES);
          end else begin
            state_d = READ;
          end
        end
        DRAIN: begin
          if (drn_q == '0) begin
            state_d = DONE;
          end else begin
            drn_d = drn_q - DW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the next state so every control output is a flop
  always_comb begin
    buf_rd_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rd_vld_d = i_clr ? 1'b0 : buf_rd_q;
    case (state_d)
      IDLE:  ;
      READ:  begin buf_rd_d = 1'b1; busy_d = 1'b1; end
      DRAIN: busy_d = 1'b1;
      DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // Control output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      buf_rd_q <= buf_rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign o_buf_rd = buf_rd_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    // Stage 0 is the capture register; stages 1..k form the skew for this lane
    logic [k:0][ELEM_WIDTH-1:0] dat_q, dat_d;
    logic [k:0]                 vld_q, vld_d;

    // Capture gates data with valid, so invalid slots carry zero padding
    always_comb begin
      dat_d = '0;
      vld_d = '0;
      if (i_clr) begin
        dat_d = '0;
        vld_d = '0;
      end else begin
        vld_d[0] = rd_vld_q;
        dat_d[0] = rd_vld_q ? i_buf_data[k*ELEM_WIDTH +: ELEM_WIDTH] : '0;
        for (int j = 1; j <= k; j++) begin
          vld_d[j] = vld_q[j-1];
          dat_d[j] = dat_q[j-1];
        end
      end
    end

    // Lane pipeline registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign o_lane_data[k*ELEM_WIDTH +: ELEM_WIDTH] = vld_q[k] ? dat_q[k] : '0;
    assign o_lane_valid[k]                          = vld_q[k];
  end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Directed-sequence bench with random buffer words; expected outputs come from the
// cycle formulas of the feeder's timing rules, not from its internal structure.
module tb_systolic_row_feeder;
  localparam int EW = 8;
  localparam int LN = 3;
  localparam int LW = 8;
  localparam int W  = LN * EW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          clr;
  logic          buf_rd;
  logic [W-1:0]  buf_data;
  logic [W-1:0]  lane_data;
  logic [LN-1:0] lane_valid;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] words[$];

  systolic_row_feeder #(.ELEM_WIDTH(EW), .LANES(LN), .LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_clr(clr),
    .o_buf_rd(buf_rd), .i_buf_data(buf_data), .o_lane_data(lane_data),
    .o_lane_valid(lane_valid), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " rd"},    32'(buf_rd),     32'd0);
    check({tag, " busy"},  32'(busy),       32'd0);
    check({tag, " done"},  32'(done),       32'd0);
    check({tag, " valid"}, 32'(lane_valid), 32'd0);
    check({tag, " data"},  32'(lane_data),  32'd0);
  endtask

  // Expected outputs of cycle c of a run of length L, optionally cleared in cycle clr_c
  task automatic check_cycle(input int c, input int L, input int clr_c);
    logic          e_rd, e_busy, e_done;
    logic [LN-1:0] e_vld;
    logic [W-1:0]  e_dat;
    logic [W-1:0]  wd;
    int            n;
    e_vld = '0;
    e_dat = '0;
    if (L == 0) begin
      e_rd = 1'b0; e_busy = 1'b0; e_done = (c == 1);
    end else begin
      e_rd   = (c >= 1) && (c <= L);
      e_busy = (c >= 1) && (c <= L + LN + 1);
      e_done = (c == L + LN + 2);
      for (int k = 0; k < LN; k++) begin
        n = c - 3 - k;
        if (n >= 0 && n < L) begin
          wd = words[n];
          e_vld[k] = 1'b1;
          e_dat[k*EW +: EW] = wd[k*EW +: EW];
        end
      end
    end
    if (clr_c > 0 && c > clr_c) begin
      e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_vld = '0; e_dat = '0;
    end
    check($sformatf("L%0d c%0d rd", L, c),    32'(buf_rd),     32'(e_rd));
    check($sformatf("L%0d c%0d busy", L, c),  32'(busy),       32'(e_busy));
    check($sformatf("L%0d c%0d done", L, c),  32'(done),       32'(e_done));
    check($sformatf("L%0d c%0d valid", L, c), 32'(lane_valid), 32'(e_vld));
    check($sformatf("L%0d c%0d data", L, c),  32'(lane_data),  32'(e_dat));
  endtask

  // Caller fills words and sits in cycle 0; this task plays the input buffer
  task automatic run(input int clr_c, input bit hold);
    int   L, rd_idx, rd_cnt, last, exp_rd;
    logic prev_rd;
    L      = words.size();
    rd_idx = 0;
    rd_cnt = 0;
    start  = 1'b1;
    len    = LW'(L);
    prev_rd = buf_rd;
    last   = (L == 0) ? 4 : L + LN + 4;
    for (int c = 1; c <= last; c++) begin
      step();
      start = hold && (c <= L + LN + 2);
      clr   = (c == clr_c);
      if (prev_rd && rd_idx < L) begin
        buf_data = words[rd_idx];
        rd_idx++;
      end else begin
        buf_data = W'($urandom);
      end
      check_cycle(c, L, clr_c);
      if (buf_rd) rd_cnt++;
      prev_rd = buf_rd;
    end
    start = 1'b0;
    clr   = 1'b0;
    exp_rd = (clr_c > 0 && clr_c < L) ? clr_c : L;
    check($sformatf("L%0d read count", L), 32'(rd_cnt), 32'(exp_rd));
  endtask

  task automatic fill_random(input int L);
    words.delete();
    for (int i = 0; i < L; i++) words.push_back(W'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; clr = 1'b0; buf_data = '0;
    step();
    step();
    check_idle("in reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle($sformatf("idle%0d", i));
    end

    // two-word directed run from the worked example
    words.delete();
    words.push_back(24'h030201);
    words.push_back(24'h060504);
    run(0, 1'b0);

    words.delete();
    run(0, 1'b0);

    fill_random(4);
    run(0, 1'b1);
    fill_random(3);
    run(0, 1'b0);

    fill_random(5);
    run(3, 1'b0);
    fill_random(5);
    run(0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_random(int'($urandom_range(1, 12)));
      run(0, 1'b0);
      step();
      check_idle($sformatf("gap%0d", r));
    end

    fill_random(255);
    run(0, 1'b0);

    // async reset in the middle of a run must clear outputs before any edge
    fill_random(6);
    start = 1'b1;
    len   = LW'(6);
    step();
    start = 1'b0;
    step();
    check("pre-reset rd", 32'(buf_rd), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async reset");
    step();
    rst_n = 1'b1;
    step();
    check_idle("post reset");

    fill_random(2);
    run(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
